// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver for an MM:SS BCD time source.
// It adds per-frame snapshotting, ghost blanking, leading-zero blanking, a blinking colon and an invalid-digit flag.
module seg7_scan_driver #(
  parameter logic [15:0] REFRESH_DIV  = 16'd50000,
  parameter logic [15:0] BLANK_CYC    = 16'd500,
  parameter logic [7:0]  COLON_FRAMES = 8'd125,
  parameter logic        SEG_ACT_LOW  = 1'b1,
  parameter logic        AN_ACT_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       blank_lz,
  input  logic [3:0] sec_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] min_tens,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       digit_err
);

  localparam logic [3:0] AN_OFF  = AN_ACT_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACT_LOW;
  localparam logic       DP_ON   = ~SEG_ACT_LOW;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  function automatic logic snap_has_bad_digit(input logic [15:0] s);
    return (s[3:0] > 4'd9) || (s[7:4] > 4'd9) || (s[11:8] > 4'd9) || (s[15:12] > 4'd9);
  endfunction

  state_t      state_r;
  logic [1:0]  idx_r;
  logic [15:0] cnt_r;
  logic [7:0]  frame_cnt_r;
  logic        colon_r;
  logic [15:0] snap_r;        // {min_tens, min_ones, sec_tens, sec_ones}
  logic [3:0]  an_r;
  logic [6:0]  seg_r;
  logic        dp_r;
  logic        digit_err_r;

  logic [3:0]  cur_digit_s;
  logic        lz_blank_s;
  logic        frame_start_s;
  logic        last_blank_s;
  logic        last_slot_s;
  logic [3:0]  an_nxt_s;
  logic [6:0]  seg_nxt_s;
  logic        dp_nxt_s;

  assign an        = an_r;
  assign seg       = seg_r;
  assign dp        = dp_r;
  assign digit_err = digit_err_r;

  // Slot position decode and digit selection from the frame snapshot.
  always_comb begin
    cur_digit_s   = snap_r[{idx_r, 2'b00} +: 4];
    lz_blank_s    = blank_lz && (idx_r == 2'd3) && (snap_r[15:12] == 4'd0);
    frame_start_s = (state_r == ST_BLANK) && (idx_r == 2'd0) && (cnt_r == 16'd0);
    last_blank_s  = (cnt_r == (BLANK_CYC - 16'd1));
    last_slot_s   = (cnt_r == (REFRESH_DIV - 16'd1));
  end

  // Output pattern for the slot position held in the state registers.
  always_comb begin
    an_nxt_s  = AN_OFF;
    seg_nxt_s = SEG_OFF;
    dp_nxt_s  = DP_OFF;
    if ((state_r == ST_DRIVE) && !lz_blank_s) begin
      an_nxt_s  = AN_ACT_LOW ? ~(4'b0001 << idx_r) : (4'b0001 << idx_r);
      seg_nxt_s = SEG_ACT_LOW ? ~bcd_to_seg(cur_digit_s) : bcd_to_seg(cur_digit_s);
      dp_nxt_s  = ((idx_r == 2'd2) && colon_r) ? DP_ON : DP_OFF;
    end else begin
      an_nxt_s  = AN_OFF;
      seg_nxt_s = SEG_OFF;
      dp_nxt_s  = DP_OFF;
    end
  end

  // Scan FSM with snapshot, colon timing, error flag and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_BLANK;
      idx_r       <= 2'd0;
      cnt_r       <= 16'd0;
      frame_cnt_r <= 8'd0;
      colon_r     <= 1'b0;
      snap_r      <= 16'd0;
      an_r        <= AN_OFF;
      seg_r       <= SEG_OFF;
      dp_r        <= DP_OFF;
      digit_err_r <= 1'b0;
    end else if (!en) begin
      state_r     <= ST_BLANK;
      idx_r       <= 2'd0;
      cnt_r       <= 16'd0;
      an_r        <= AN_OFF;
      seg_r       <= SEG_OFF;
      dp_r        <= DP_OFF;
      digit_err_r <= digit_err_r | snap_has_bad_digit(snap_r);
    end else begin
      an_r        <= an_nxt_s;
      seg_r       <= seg_nxt_s;
      dp_r        <= dp_nxt_s;
      // Checks the snapshot taken on the previous edge, so the flag lags it by one cycle.
      digit_err_r <= digit_err_r | snap_has_bad_digit(snap_r);
      if (frame_start_s) begin
        snap_r <= {min_tens, min_ones, sec_tens, sec_ones};
      end
      case (state_r)
        ST_BLANK: begin
          cnt_r <= cnt_r + 16'd1;
          if (last_blank_s) begin
            state_r <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (last_slot_s) begin
            cnt_r   <= 16'd0;
            state_r <= ST_BLANK;
            idx_r   <= idx_r + 2'd1;
            if (idx_r == 2'd3) begin
              if (frame_cnt_r == (COLON_FRAMES - 8'd1)) begin
                frame_cnt_r <= 8'd0;
                colon_r     <= ~colon_r;
              end else begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
              end
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= ST_BLANK;
          cnt_r   <= 16'd0;
          idx_r   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a frame-position reference model checked on every cycle,
// plus directed literal checks and randomized digit/enable stimulus.
module tb_seg7_scan_driver;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int CF    = 2;
  localparam int FRAME = 4 * RD;
  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic       clk = 1'b0;
  logic       rst, en, blank_lz;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, digit_err;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(
    .REFRESH_DIV(16'd8), .BLANK_CYC(16'd2), .COLON_FRAMES(8'd2),
    .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .blank_lz(blank_lz),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .an(an), .seg(seg), .dp(dp), .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    if (d > 4'd9) return 7'h40;
    return SEG_TAB[d];
  endfunction

  // Reference model: frame position counter since the scan (re)started.
  int         m_e, m_frames, p, d, q;
  logic [3:0] m_snap [4];
  logic       m_err, m_seg_chk;
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic       m_dp;

  initial begin
    m_e = 0; m_frames = 0; m_err = 1'b0;
    for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
    m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1; m_seg_chk = 1'b1;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_e = 0; m_frames = 0; m_err = 1'b0;
        for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
        m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1; m_seg_chk = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) if (m_snap[i] > 4'd9) m_err = 1'b1;
        if (!en) begin
          m_e = 0;
          m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1; m_seg_chk = 1'b1;
        end else begin
          p = m_e % FRAME;
          if (p == 0) begin
            m_snap[0] = sec_ones; m_snap[1] = sec_tens;
            m_snap[2] = min_ones; m_snap[3] = min_tens;
          end
          d = p / RD;
          q = p % RD;
          if (q < BC || (d == 3 && blank_lz && m_snap[3] == 4'd0)) begin
            m_an = 4'hF; m_dp = 1'b1; m_seg_chk = 1'b0;
          end else begin
            m_an = ~(4'b0001 << d);
            m_seg = ~seg_of(m_snap[d]);
            m_dp = !(d == 2 && ((m_frames / CF) % 2 == 1));
            m_seg_chk = 1'b1;
          end
          if (p == FRAME - 1) m_frames++;
          m_e++;
        end
      end
      #2;
      chk("an", an, m_an);
      chk("dp", dp, m_dp);
      chk("digit_err", digit_err, m_err);
      chk("an_onehot0", $onehot0(~an), 1'b1);
      if (m_seg_chk) chk("seg", seg, m_seg);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b1; en = 1'b1; blank_lz = 1'b0;
    min_tens = 4'd1; min_ones = 4'd2; sec_tens = 4'd3; sec_ones = 4'd4;
    tick(2);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_err", digit_err, 1'b0);
    rst = 1'b0;
    tick(2);
    chk("first_blank_an", an, 4'hF);
    tick(1);
    chk("first_drive_an", an, 4'hE);
    chk("first_drive_seg", seg, 7'h19);
    tick(8);
    chk("slot1_an", an, 4'hD);
    chk("slot1_seg", seg, 7'h30);
    tick(7);
    sec_ones = 4'd7;
    tick(17);
    chk("snap_next_an", an, 4'hE);
    chk("snap_next_seg", seg, 7'h78);
    tick(16);
    chk("colon_off_an", an, 4'hB);
    chk("colon_off_dp", dp, 1'b1);
    tick(32);
    chk("colon_on_an", an, 4'hB);
    chk("colon_on_dp", dp, 1'b0);

    min_tens = 4'd0; blank_lz = 1'b1;
    tick(40);
    for (int i = 0; i < 64; i++) begin
      tick(1);
      chk("lz_an3_off", an[3], 1'b1);
    end
    blank_lz = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (an == 4'h7) begin
        found = 1'b1;
        chk("lz_off_seg", seg, 7'h40);
      end
    end
    chk("lz_off_seen", found, 1'b1);

    min_tens = 4'd1;
    restart();
    tick(20);
    en = 1'b0;
    tick(1);
    chk("en_off_an", an, 4'hF);
    tick(3);
    en = 1'b1;
    tick(2);
    chk("en_on_blank", an, 4'hF);
    tick(1);
    chk("en_on_drive", an, 4'hE);

    sec_tens = 4'hC;
    tick(40);
    chk("bad_err_set", digit_err, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (an == 4'hD) begin
        found = 1'b1;
        chk("bad_dash_seg", seg, 7'h3F);
      end
    end
    chk("bad_dash_seen", found, 1'b1);
    sec_tens = 4'd3;
    tick(70);
    chk("bad_err_sticky", digit_err, 1'b1);
    tick(3);
    rst = 1'b1;
    #1;
    chk("async_rst_an", an, 4'hF);
    chk("async_rst_err", digit_err, 1'b0);
    tick(1);
    rst = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      tick(1);
      case ($urandom_range(0, 9))
        0: sec_ones = 4'($urandom_range(0, 9));
        1: sec_tens = 4'($urandom_range(0, 5));
        2: min_ones = 4'($urandom_range(0, 9));
        3: min_tens = 4'($urandom_range(0, 2));
        default: ;
      endcase
      if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 149) == 0) en = ~en;
      if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      if ($urandom_range(0, 999) == 0) sec_ones = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 1499) == 0) rst = 1'b1;
      else rst = 1'b0;
    end
    rst = 1'b0;
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
